// File: rtl/oled_pkg.sv
// Shared definitions for the OLED frame-buffer streamer.
// Holds the FSM state encoding, the SSD1306 control bytes, the frame size,
// and the 7-byte command sequence that opens the full column/page window.
package oled_pkg;

  localparam int          OLED_FB_BYTES  = 1024;
  localparam int          OLED_ADDR_W    = 10;
  localparam logic [7:0]  OLED_CTRL_CMD  = 8'h00;
  localparam logic [7:0]  OLED_CTRL_DATA = 8'h40;
  localparam int          CMD_LEN        = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DPRE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_SEND,
    ST_DONE
  } state_t;

  // Command transaction: control byte, then column window 0..127 and page window 0..7.
  function automatic logic [7:0] win_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    win_cmd = OLED_CTRL_CMD;
      3'd1:    win_cmd = 8'h21;
      3'd2:    win_cmd = 8'h00;
      3'd3:    win_cmd = 8'h7F;
      3'd4:    win_cmd = 8'h22;
      3'd5:    win_cmd = 8'h00;
      3'd6:    win_cmd = 8'h07;
      default: win_cmd = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/oled_fb_streamer.sv
// oled_fb_streamer
// Reads one frame out of the selected frame-buffer RAM and streams it to a
// byte-level I2C master as SSD1306 payload: a 7-byte command transaction that
// sets the full display window, then a data transaction of CTRL_DATA followed
// by FB_BYTES frame bytes.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, frame_sel      refresh request (IDLE only) and buffer to send
//   busy, frame_done      frame in progress / one-cycle completion pulse
//   nack_err              one-cycle pulse when a frame is aborted by a NACK
//   rd_sel, rd_addr       latched buffer select and RAM address (registered)
//   rd_data               RAM read data, valid one cycle after rd_addr
//   tx_valid/ready/data   byte handshake to the I2C master
//   tx_first, tx_last     START-before / STOP-after qualifiers for tx_data
//   tx_nack               one-cycle NACK pulse from the master
module oled_fb_streamer
  import oled_pkg::*;
#(
  parameter int         FB_BYTES  = OLED_FB_BYTES,
  parameter int         ADDR_W    = OLED_ADDR_W,
  parameter logic [7:0] CTRL_CMD  = OLED_CTRL_CMD,
  parameter logic [7:0] CTRL_DATA = OLED_CTRL_DATA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        frame_sel,
  output logic              busy,
  output logic              frame_done,
  output logic              nack_err,
  output logic [1:0]        rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_first,
  output logic              tx_last,
  input  logic              tx_nack
);

  state_t      state, state_nxt;
  logic [2:0]  cmd_idx;
  logic [7:0]  data_p1;
  logic        addr_last;
  logic        start_acc, cmd_adv, addr_clr, addr_inc, data_cap;

  assign addr_last = (rd_addr == ADDR_W'(FB_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Outputs are decoded from registered state, so the offered byte cannot
  // change until the state (or index) moves on an accept.
  always_comb begin
    state_nxt  = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_first   = 1'b0;
    tx_last    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    start_acc  = 1'b0;
    cmd_adv    = 1'b0;
    addr_clr   = 1'b0;
    addr_inc   = 1'b0;
    data_cap   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        tx_valid = 1'b1;
        tx_data  = (cmd_idx == 3'd0) ? CTRL_CMD : win_cmd(cmd_idx);
        tx_first = (cmd_idx == 3'd0);
        tx_last  = (cmd_idx == 3'(CMD_LEN - 1));
        if (tx_ready) begin
          cmd_adv = 1'b1;
          if (tx_last) state_nxt = ST_DPRE;
        end
      end
      ST_DPRE: begin
        tx_valid = 1'b1;
        tx_data  = CTRL_DATA;
        tx_first = 1'b1;
        if (tx_ready) begin
          addr_clr  = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH:   state_nxt = ST_WAIT_RD;
      ST_WAIT_RD: begin
        data_cap  = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = data_p1;
        tx_last  = addr_last;
        if (tx_ready) begin
          if (addr_last) begin
            state_nxt = ST_DONE;
          end else begin
            addr_inc  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A NACK aborts the frame; a byte offered in the same cycle is dropped.
    if (state != ST_IDLE && tx_nack) begin
      state_nxt = ST_IDLE;
      cmd_adv   = 1'b0;
      addr_clr  = 1'b0;
      addr_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_sel   <= 2'd0;
      rd_addr  <= '0;
      cmd_idx  <= 3'd0;
      nack_err <= 1'b0;
    end else begin
      nack_err <= tx_nack && (state != ST_IDLE);
      if (start_acc) begin
        rd_sel  <= frame_sel;
        cmd_idx <= 3'd0;
      end
      if (cmd_adv)  cmd_idx <= cmd_idx + 3'd1;
      if (addr_clr) rd_addr <= '0;
      if (addr_inc) rd_addr <= rd_addr + ADDR_W'(1);
    end
  end

  // RAM read data stage: captured in WAIT_RD, offered in SEND.
  always_ff @(posedge clk) begin
    if (data_cap) data_p1 <= rd_data;
  end

endmodule

// File: tb/tb_oled_fb_streamer.sv
module tb_oled_fb_streamer;

  logic       clk = 1'b0;
  logic       rst_n, start, tx_ready, tx_nack;
  logic [1:0] frame_sel;
  logic       busy, frame_done, nack_err, tx_valid, tx_first, tx_last;
  logic [1:0] rd_sel;
  logic [9:0] rd_addr;
  logic [7:0] rd_data, tx_data;

  always #5 clk = ~clk;

  oled_fb_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_sel(frame_sel),
    .busy(busy), .frame_done(frame_done), .nack_err(nack_err),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_first(tx_first), .tx_last(tx_last), .tx_nack(tx_nack)
  );

  // Four frame buffers: byte k of buffer s is k[7:0] ^ key[s]; buffer 2 holds k[7:0].
  logic [7:0] key [4];
  initial key = '{8'h3C, 8'hA5, 8'h00, 8'h5A};

  always_ff @(posedge clk) rd_data <= rd_addr[7:0] ^ key[rd_sel];

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
  } hdr_t;

  typedef struct {
    int sel;
    bit stall;
    int nack_at;
    int rst_at;
    bit extra_start;
    bit chg_sel;
    int exp_done;
    int exp_nack;
    int exp_cnt;
  } scen_t;

  hdr_t  hdr [8];
  scen_t scen [6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt, nack_cnt;
  logic [9:0] got [$];
  int         acc_cyc [$];
  bit         hold_prev = 0;
  logic [9:0] prev_byte;
  bit         track_sel = 0;
  logic [1:0] exp_rd_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample outputs and the inputs applied for this cycle at the
  // falling edge, then return just after the next rising edge.
  task automatic run_cycle();
    @(negedge clk);
    if (hold_prev) begin
      chk("stall_valid", tx_valid, 1);
      chk("stall_byte", {tx_first, tx_last, tx_data}, prev_byte);
    end
    if (track_sel && busy) chk("rd_sel", rd_sel, exp_rd_sel);
    if (rst_n && tx_valid && tx_ready && !tx_nack) begin
      got.push_back({tx_first, tx_last, tx_data});
      acc_cyc.push_back(cyc);
    end
    if (frame_done) done_cnt++;
    if (nack_err)   nack_cnt++;
    hold_prev = rst_n && tx_valid && !tx_ready && !tx_nack;
    prev_byte = {tx_first, tx_last, tx_data};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, frame_done, 0);
    chk({nm, "_nack"}, nack_err, 0);
    chk({nm, "_valid"}, tx_valid, 0);
    chk({nm, "_data"}, {tx_first, tx_last, tx_data}, 0);
    chk({nm, "_rdaddr"}, rd_addr, 0);
    chk({nm, "_rdsel"}, rd_sel, 0);
  endtask

  task automatic run_frame(input scen_t s, input int id);
    int  di;
    bit  ended;
    logic [9:0] e;
    got.delete();
    acc_cyc.delete();
    done_cnt = 0;
    nack_cnt = 0;
    exp_rd_sel = 2'(s.sel);
    frame_sel = 2'(s.sel);
    tx_ready = 1'b1;
    start = 1'b1;
    run_cycle();
    start = 1'b0;
    if (s.chg_sel) frame_sel = 2'd1;
    chk($sformatf("s%0d_busy_after_start", id), busy, 1);
    chk($sformatf("s%0d_valid_after_start", id), tx_valid, 1);
    track_sel = 1;
    ended = 0;
    for (int n = 0; n < 8000 && !ended; n++) begin
      tx_ready = s.stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      tx_nack = 1'b0;
      start = 1'b0;
      di = got.size() - 8;
      if (s.nack_at >= 0 && tx_valid && di == s.nack_at) begin
        tx_nack = 1'b1;
        tx_ready = 1'b1;
        run_cycle();
        tx_nack = 1'b0;
        chk($sformatf("s%0d_nack_valid", id), tx_valid, 0);
        chk($sformatf("s%0d_nack_err", id), nack_err, 1);
        chk($sformatf("s%0d_nack_busy", id), busy, 0);
        run_cycle();
        chk($sformatf("s%0d_nack_err_pulse", id), nack_err, 0);
        ended = 1;
      end else if (s.rst_at >= 0 && tx_valid && di == s.rst_at) begin
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        check_outputs_zero($sformatf("s%0d_midrst", id));
        ended = 1;
      end else begin
        if (s.extra_start && di == 300) start = 1'b1;
        if (frame_done) begin
          if (s.extra_start) start = 1'b1;
          run_cycle();
          start = 1'b0;
          ended = 1;
        end else begin
          run_cycle();
        end
      end
    end
    track_sel = 0;
    if (!ended) begin
      errors++;
      $display("FAIL s%0d_timeout got no end expected end within 8000 cycles", id);
    end
    tx_ready = 1'b1;
    tx_nack = 1'b0;
    start = 1'b0;
    for (int n = 0; n < 20; n++) run_cycle();
    chk($sformatf("s%0d_done_count", id), done_cnt, s.exp_done);
    chk($sformatf("s%0d_nack_count", id), nack_cnt, s.exp_nack);
    chk($sformatf("s%0d_byte_count", id), got.size(), 8 + s.exp_cnt);
    chk($sformatf("s%0d_idle_busy", id), busy, 0);
    chk($sformatf("s%0d_idle_valid", id), tx_valid, 0);
    for (int i = 0; i < got.size(); i++) begin
      if (i < 8) begin
        e = {hdr[i].first, hdr[i].last, hdr[i].data};
      end else begin
        e = {1'b0, (i - 8) == 1023, 8'(i - 8) ^ key[s.sel]};
      end
      chk($sformatf("s%0d_byte%0d", id, i), got[i], e);
    end
    if (!s.stall && s.nack_at < 0 && s.rst_at < 0 && !s.extra_start) begin
      for (int i = 8; i < acc_cyc.size(); i++)
        chk($sformatf("s%0d_latency%0d", id, i), acc_cyc[i] - acc_cyc[i-1], 3);
    end
  endtask

  initial begin
    hdr[0] = '{8'h00, 1'b1, 1'b0};
    hdr[1] = '{8'h21, 1'b0, 1'b0};
    hdr[2] = '{8'h00, 1'b0, 1'b0};
    hdr[3] = '{8'h7F, 1'b0, 1'b0};
    hdr[4] = '{8'h22, 1'b0, 1'b0};
    hdr[5] = '{8'h00, 1'b0, 1'b0};
    hdr[6] = '{8'h07, 1'b0, 1'b1};
    hdr[7] = '{8'h40, 1'b1, 1'b0};
    //           sel stall nack rst  xst chg done nack cnt
    scen[0] = '{2, 1'b0, -1,  -1, 1'b0, 1'b0, 1, 0, 1024};
    scen[1] = '{0, 1'b1, -1,  -1, 1'b0, 1'b0, 1, 0, 1024};
    scen[2] = '{1, 1'b0, 500, -1, 1'b0, 1'b0, 0, 1, 500};
    scen[3] = '{2, 1'b1, -1,  -1, 1'b1, 1'b0, 1, 0, 1024};
    scen[4] = '{3, 1'b0, -1,  10, 1'b0, 1'b0, 0, 0, 10};
    scen[5] = '{3, 1'b0, -1,  -1, 1'b0, 1'b1, 1, 0, 1024};

    rst_n = 1'b0;
    start = 1'b0;
    frame_sel = 2'd0;
    tx_ready = 1'b1;
    tx_nack = 1'b0;
    run_cycle();
    run_cycle();
    rst_n = 1'b1;
    check_outputs_zero("reset");

    // NACK while idle must not raise nack_err or start anything.
    tx_nack = 1'b1;
    run_cycle();
    tx_nack = 1'b0;
    run_cycle();
    chk("idle_nack_err", nack_cnt, 0);
    chk("idle_nack_busy", busy, 0);

    for (int k = 0; k < 6; k++) run_frame(scen[k], k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
